// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types for the SPU dual-issue scheduler: unit ids, unit latencies,
// held-instruction record and scheduler state encoding.
package dual_issue_scheduler_pkg;

    localparam int REG_AW   = 7;
    localparam int UNIT_W   = 3;
    localparam int LAT_BITS = 3;

    typedef enum logic [UNIT_W-1:0] {
        UNIT_FX1    = 3'd0,
        UNIT_BYTE   = 3'd1,
        UNIT_FX2    = 3'd2,
        UNIT_PERM   = 3'd3,
        UNIT_BRANCH = 3'd4,
        UNIT_SP_FP  = 3'd5,
        UNIT_LS     = 3'd6,
        UNIT_SP_INT = 3'd7
    } unit_e;

    // Cycles until a result reaches its forwarding point
    localparam logic [LAT_BITS-1:0] LAT_FX1    = 3'd2;
    localparam logic [LAT_BITS-1:0] LAT_BYTE   = 3'd3;
    localparam logic [LAT_BITS-1:0] LAT_FX2    = 3'd3;
    localparam logic [LAT_BITS-1:0] LAT_PERM   = 3'd3;
    localparam logic [LAT_BITS-1:0] LAT_BRANCH = 3'd3;
    localparam logic [LAT_BITS-1:0] LAT_SP_FP  = 3'd6;
    localparam logic [LAT_BITS-1:0] LAT_LS     = 3'd6;
    localparam logic [LAT_BITS-1:0] LAT_SP_INT = 3'd7;

    typedef struct packed {
        logic              valid;
        logic              pipe;
        logic [UNIT_W-1:0] unit;
        logic [2:0]        src_used;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rc;
        logic              wr_en;
        logic [REG_AW-1:0] rt;
    } sched_instr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAIR   = 2'd1,
        SECOND = 2'd2
    } sched_state_e;

    function automatic logic [LAT_BITS-1:0] unit_latency(input logic [UNIT_W-1:0] unit);
        case (unit)
            UNIT_FX1:    return LAT_FX1;
            UNIT_BYTE:   return LAT_BYTE;
            UNIT_FX2:    return LAT_FX2;
            UNIT_PERM:   return LAT_PERM;
            UNIT_BRANCH: return LAT_BRANCH;
            UNIT_SP_FP:  return LAT_SP_FP;
            UNIT_LS:     return LAT_LS;
            default:     return LAT_SP_INT;
        endcase
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_reg_scoreboard.sv
// Per-register latency countdowns with two set ports and six source-ready
// read ports; a source is ready once its count is 0 or 1.
module dual_issue_scheduler_reg_scoreboard #(
    parameter int REG_ADDR_WIDTH = 7,
    parameter int LAT_W          = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           set0_en,
    input  logic [REG_ADDR_WIDTH-1:0]      set0_addr,
    input  logic [LAT_W-1:0]               set0_lat,
    input  logic                           set1_en,
    input  logic [REG_ADDR_WIDTH-1:0]      set1_addr,
    input  logic [LAT_W-1:0]               set1_lat,
    input  logic [5:0][REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [5:0]                     rd_ready
);

    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [LAT_W-1:0] cnt [NREG];

    // A fresh issue wins over the running decrement on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (set1_en && set1_addr == REG_ADDR_WIDTH'(r))
                    cnt[r] <= set1_lat;
                else if (set0_en && set0_addr == REG_ADDR_WIDTH'(r))
                    cnt[r] <= set0_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_comb begin
        rd_ready = '0;
        for (int p = 0; p < 6; p++)
            rd_ready[p] = (cnt[rd_addr[p]] <= LAT_W'(1));
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler (decode -> register fetch) with RAW,
// structural and intra-pair hazard stalls. Optional stats: SCHED_STATS_EN.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 7,
    parameter int UNIT_ID_SIZE   = 3,
    parameter int LAT_W          = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic                      i1_valid,
    input  logic                      i1_pipe,
    input  logic [UNIT_ID_SIZE-1:0]   i1_unit,
    input  logic [2:0]                i1_src_used,
    input  logic [REG_ADDR_WIDTH-1:0] i1_ra,
    input  logic [REG_ADDR_WIDTH-1:0] i1_rb,
    input  logic [REG_ADDR_WIDTH-1:0] i1_rc,
    input  logic                      i1_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i1_rt,
    input  logic                      i2_valid,
    input  logic                      i2_pipe,
    input  logic [UNIT_ID_SIZE-1:0]   i2_unit,
    input  logic [2:0]                i2_src_used,
    input  logic [REG_ADDR_WIDTH-1:0] i2_ra,
    input  logic [REG_ADDR_WIDTH-1:0] i2_rb,
    input  logic [REG_ADDR_WIDTH-1:0] i2_rc,
    input  logic                      i2_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i2_rt,
    output logic                      issue_even_valid,
    output logic                      issue_odd_valid,
    output logic                      issue_even_slot,
    output logic                      issue_odd_slot,
    output logic                      dep_stall_instr2,
    output logic                      stall
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]               stat_dual,
    output logic [31:0]               stat_single,
    output logic [31:0]               stat_stall
`endif
);

    sched_state_e state, state_nxt;
    sched_instr_t ins1, ins2;
    logic [5:0][REG_ADDR_WIDTH-1:0] rd_addr;
    logic [5:0] src_rdy;
    logic rdy1, rdy2, raw12, pair_conflict;
    logic issue1, issue2, dep_nxt, stall_nxt, accept;

    assign rd_addr = {ins2.ra, ins2.rb, ins2.rc, ins1.ra, ins1.rb, ins1.rc};
    assign rdy1    = ins1.valid && (&(~ins1.src_used | src_rdy[2:0]));
    assign rdy2    = ins2.valid && (&(~ins2.src_used | src_rdy[5:3]));

    assign raw12 = ins1.wr_en && ((ins2.src_used[2] && ins2.ra == ins1.rt) ||
                                  (ins2.src_used[1] && ins2.rb == ins1.rt) ||
                                  (ins2.src_used[0] && ins2.rc == ins1.rt));
    assign pair_conflict = (ins1.pipe == ins2.pipe) || raw12 ||
                           (ins1.wr_en && ins2.wr_en && ins1.rt == ins2.rt);

    dual_issue_scheduler_reg_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .LAT_W          (LAT_W)
    ) u_reg_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set0_en   (issue1 && ins1.wr_en),
        .set0_addr (ins1.rt),
        .set0_lat  (unit_latency(ins1.unit)),
        .set1_en   (issue2 && ins2.wr_en),
        .set1_addr (ins2.rt),
        .set1_lat  (unit_latency(ins2.unit)),
        .rd_addr   (rd_addr),
        .rd_ready  (src_rdy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue1    = 1'b0;
        issue2    = 1'b0;
        dep_nxt   = 1'b0;
        case (state)
            IDLE: ;
            PAIR: begin
                if (!ins2.valid) begin
                    if (rdy1) begin
                        issue1    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (rdy1 && rdy2 && !pair_conflict) begin
                    issue1    = 1'b1;
                    issue2    = 1'b1;
                    state_nxt = IDLE;
                end else if (rdy1) begin
                    issue1    = 1'b1;
                    dep_nxt   = 1'b1;
                    state_nxt = SECOND;
                end
            end
            SECOND: begin
                if (rdy2) begin
                    issue2    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            issue1    = 1'b0;
            issue2    = 1'b0;
            dep_nxt   = 1'b0;
            state_nxt = IDLE;
        end
        stall_nxt = (state != IDLE) && !issue1 && !issue2 && !flush;
        // Ready whenever nothing will still be held after this edge
        in_ready  = !flush && (state_nxt == IDLE);
        accept    = in_valid && in_ready;
        if (accept) begin
            if (i1_valid)      state_nxt = PAIR;
            else if (i2_valid) state_nxt = SECOND;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ins1 <= '{valid: i1_valid, pipe: i1_pipe, unit: i1_unit, src_used: i1_src_used,
                      ra: i1_ra, rb: i1_rb, rc: i1_rc, wr_en: i1_wr_en, rt: i1_rt};
            ins2 <= '{valid: i2_valid, pipe: i2_pipe, unit: i2_unit, src_used: i2_src_used,
                      ra: i2_ra, rb: i2_rb, rc: i2_rc, wr_en: i2_wr_en, rt: i2_rt};
        end
    end

    // Issue boundary: strobes are steered per pipe, slot names the instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_even_valid <= 1'b0;
            issue_odd_valid  <= 1'b0;
            issue_even_slot  <= 1'b0;
            issue_odd_slot   <= 1'b0;
            dep_stall_instr2 <= 1'b0;
            stall            <= 1'b0;
        end else begin
            issue_even_valid <= (issue1 && !ins1.pipe) || (issue2 && !ins2.pipe);
            issue_odd_valid  <= (issue1 && ins1.pipe) || (issue2 && ins2.pipe);
            issue_even_slot  <= issue2 && !ins2.pipe;
            issue_odd_slot   <= issue2 && ins2.pipe;
            dep_stall_instr2 <= dep_nxt;
            stall            <= stall_nxt;
        end
    end

`ifdef SCHED_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_dual   <= '0;
            stat_single <= '0;
            stat_stall  <= '0;
        end else begin
            stat_dual   <= sat_inc(stat_dual, issue1 && issue2);
            stat_single <= sat_inc(stat_single, issue1 ^ issue2);
            stat_stall  <= sat_inc(stat_stall, stall_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: queue-based reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_dual_issue_scheduler;
    import dual_issue_scheduler_pkg::*;

    logic clk, reset, in_valid, in_ready, flush;
    sched_instr_t s1, s2;
    logic issue_even_valid, issue_odd_valid, issue_even_slot, issue_odd_slot;
    logic dep_stall_instr2, stall;
`ifdef SCHED_STATS_EN
    logic [31:0] st_dual, st_single, st_stall;
`endif

    dual_issue_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .i1_valid(s1.valid), .i1_pipe(s1.pipe), .i1_unit(s1.unit), .i1_src_used(s1.src_used),
        .i1_ra(s1.ra), .i1_rb(s1.rb), .i1_rc(s1.rc), .i1_wr_en(s1.wr_en), .i1_rt(s1.rt),
        .i2_valid(s2.valid), .i2_pipe(s2.pipe), .i2_unit(s2.unit), .i2_src_used(s2.src_used),
        .i2_ra(s2.ra), .i2_rb(s2.rb), .i2_rc(s2.rc), .i2_wr_en(s2.wr_en), .i2_rt(s2.rt),
        .issue_even_valid(issue_even_valid), .issue_odd_valid(issue_odd_valid),
        .issue_even_slot(issue_even_slot), .issue_odd_slot(issue_odd_slot),
        .dep_stall_instr2(dep_stall_instr2), .stall(stall)
`ifdef SCHED_STATS_EN
        , .stat_dual(st_dual), .stat_single(st_single), .stat_stall(st_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncomp = 0;
    int nfail = 0;

    // Reference model: list of held instructions in program order
    typedef struct {
        bit pipe; int unit; bit [2:0] used; int ra; int rb; int rc; bit wr; int rt; bit slot;
    } mins_t;
    mins_t pend[$];
    int    mcnt[128];
    bit    e_ev, e_od, e_es, e_os, e_dep, e_stall, e_rdy;

    // observation counters for the directed scenarios
    int o_even, o_odd, o_dual, o_dep, o_stall, o_odd_s1;

    function automatic int lat_of(int unit);
        case (unit)
            0:             return 2;
            1, 2, 3, 4:    return 3;
            5, 6:          return 6;
            default:       return 7;
        endcase
    endfunction

    function automatic bit m_ready(mins_t x);
        return (!x.used[2] || mcnt[x.ra] <= 1) && (!x.used[1] || mcnt[x.rb] <= 1) &&
               (!x.used[0] || mcnt[x.rc] <= 1);
    endfunction

    function automatic bit m_reads(mins_t b, mins_t a);
        return a.wr && ((b.used[2] && b.ra == a.rt) || (b.used[1] && b.rb == a.rt) ||
                        (b.used[0] && b.rc == a.rt));
    endfunction

    function automatic mins_t conv(sched_instr_t s, bit slot);
        mins_t m;
        m.pipe = s.pipe; m.unit = int'(s.unit); m.used = s.src_used;
        m.ra = int'(s.ra); m.rb = int'(s.rb); m.rc = int'(s.rc);
        m.wr = s.wr_en; m.rt = int'(s.rt); m.slot = slot;
        return m;
    endfunction

    task automatic model_step(input bit v, input bit fl, input sched_instr_t a, input sched_instr_t b);
        int n;
        mins_t x;
        n = 0;
        if (!fl) begin
            if (pend.size() == 2) begin
                if (m_ready(pend[0]) && m_ready(pend[1]) && pend[0].pipe != pend[1].pipe &&
                    !m_reads(pend[1], pend[0]) &&
                    !(pend[0].wr && pend[1].wr && pend[0].rt == pend[1].rt)) n = 2;
                else if (m_ready(pend[0])) n = 1;
            end else if (pend.size() == 1 && m_ready(pend[0])) n = 1;
        end
        e_rdy   = !fl && (pend.size() == n);
        e_dep   = (n == 1 && pend.size() == 2);
        e_stall = !fl && pend.size() != 0 && n == 0;
        e_ev = 0; e_od = 0; e_es = 0; e_os = 0;
        for (int r = 0; r < 128; r++) if (mcnt[r] > 0) mcnt[r]--;
        for (int k = 0; k < n; k++) begin
            x = pend.pop_front();
            if (x.pipe) begin e_od = 1; e_os = x.slot; end
            else        begin e_ev = 1; e_es = x.slot; end
            if (x.wr) mcnt[x.rt] = lat_of(x.unit);
        end
        if (fl) pend.delete();
        if (v && e_rdy) begin
            if (a.valid) pend.push_back(conv(a, 1'b0));
            if (b.valid) pend.push_back(conv(b, 1'b1));
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int r = 0; r < 128; r++) mcnt[r] = 0;
        e_ev = 0; e_od = 0; e_es = 0; e_os = 0; e_dep = 0; e_stall = 0;
    endtask

    function automatic void chk(string nm, logic act, logic exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0b, expected %0b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk_int(string nm, int act, int exp);
        ncomp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic sched_instr_t mk(bit v, bit pipe, logic [2:0] unit, logic [2:0] used,
                                        int ra, bit wr, int rt);
        sched_instr_t s;
        s.valid = v; s.pipe = pipe; s.unit = unit; s.src_used = used;
        s.ra = REG_AW'(ra); s.rb = REG_AW'(ra + 1); s.rc = REG_AW'(ra + 2);
        s.wr_en = wr; s.rt = REG_AW'(rt);
        return s;
    endfunction

    function automatic sched_instr_t mk_rand();
        sched_instr_t s;
        s.valid = ($urandom_range(0, 3) != 0); s.pipe = 1'($urandom());
        s.unit = 3'($urandom()); s.src_used = 3'($urandom());
        s.ra = REG_AW'($urandom_range(0, 7)); s.rb = REG_AW'($urandom_range(0, 7));
        s.rc = REG_AW'($urandom_range(0, 7)); s.wr_en = 1'($urandom());
        s.rt = REG_AW'($urandom_range(0, 7));
        return s;
    endfunction

    task automatic clr_obs();
        o_even = 0; o_odd = 0; o_dual = 0; o_dep = 0; o_stall = 0; o_odd_s1 = 0;
    endtask

    // One clock: drive, check in_ready, advance model, check registered outputs
    task automatic step(input bit v, input bit fl, input sched_instr_t a, input sched_instr_t b);
        @(negedge clk);
        in_valid = v; flush = fl; s1 = a; s2 = b;
        #1;
        model_step(v, fl, a, b);
        chk("in_ready", in_ready, e_rdy);
        @(posedge clk);
        #1;
        chk("even_valid", issue_even_valid, e_ev);
        chk("odd_valid", issue_odd_valid, e_od);
        chk("even_slot", issue_even_slot, e_es);
        chk("odd_slot", issue_odd_slot, e_os);
        chk("dep_stall", dep_stall_instr2, e_dep);
        chk("stall", stall, e_stall);
        o_even  += int'(issue_even_valid);
        o_odd   += int'(issue_odd_valid);
        o_dual  += int'(issue_even_valid && issue_odd_valid);
        o_dep   += int'(dep_stall_instr2);
        o_stall += int'(stall);
        o_odd_s1 += int'(issue_odd_valid && issue_odd_slot);
    endtask

    task automatic idle(input int n);
        sched_instr_t z;
        z = mk(0, 0, 3'd0, 3'd0, 0, 0, 0);
        for (int i = 0; i < n; i++) step(0, 0, z, z);
    endtask

    sched_instr_t nop;

    initial begin
        nop = mk(0, 0, 3'd0, 3'd0, 0, 0, 0);
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; s1 = nop; s2 = nop;
        model_reset();
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_even", issue_even_valid, 1'b0);
        chk("rst_odd", issue_odd_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_dep", dep_stall_instr2, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // independent fx1 even + perm odd -> dual issue, slots 0/1
        clr_obs();
        step(1, 0, mk(1, 0, UNIT_FX1, 3'b000, 0, 1, 5), mk(1, 1, UNIT_PERM, 3'b000, 0, 1, 6));
        step(0, 0, nop, nop);
        chk("dual_even", issue_even_valid, 1'b1);
        chk("dual_odd", issue_odd_valid, 1'b1);
        chk("dual_even_slot", issue_even_slot, 1'b0);
        chk("dual_odd_slot", issue_odd_slot, 1'b1);
        // reader of r6 (perm, 3 cycles) latched right away waits exactly one cycle
        clr_obs();
        step(1, 0, mk(1, 0, UNIT_FX1, 3'b100, 6, 0, 0), nop);
        idle(3);
        chk_int("cnt6_stall_cycles", o_stall, 1);

        // intra-pair RAW on r5
        idle(4); clr_obs();
        step(1, 0, mk(1, 0, UNIT_FX1, 3'b000, 0, 1, 5), mk(1, 1, UNIT_FX1, 3'b100, 5, 0, 0));
        idle(5);
        chk_int("raw_dep_cycles", o_dep, 1);
        chk_int("raw_instr2_issues", o_odd_s1, 1);
        chk_int("raw_stall_cycles", o_stall, 1);

        // sp_int to r9, back-to-back pair reading r9
        idle(4); clr_obs();
        step(1, 0, mk(1, 0, UNIT_SP_INT, 3'b000, 0, 1, 9), nop);
        step(1, 0, mk(1, 0, UNIT_FX1, 3'b100, 9, 0, 0), mk(1, 1, UNIT_FX1, 3'b000, 40, 0, 0));
        idle(10);
        chk_int("spint_stall_cycles", o_stall, 6);
        chk_int("spint_dual_cycles", o_dual, 1);

        // two even-pipe instructions -> serial, consecutive
        idle(4); clr_obs();
        step(1, 0, mk(1, 0, UNIT_FX1, 3'b000, 0, 1, 10), mk(1, 0, UNIT_FX1, 3'b000, 0, 1, 11));
        idle(4);
        chk_int("even_even_issues", o_even, 2);
        chk_int("even_even_dual", o_dual, 0);
        chk_int("even_even_stalls", o_stall, 0);

        // flush while instr2 waits in SECOND
        idle(4); clr_obs();
        step(1, 0, mk(1, 0, UNIT_BYTE, 3'b000, 0, 1, 20), mk(1, 1, UNIT_FX1, 3'b100, 20, 0, 0));
        step(0, 0, nop, nop);
        step(0, 1, nop, nop);
        flush = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 1'b1);
        idle(4);
        chk_int("flush_instr2_dropped", o_odd, 0);
        step(1, 0, mk(1, 1, UNIT_FX1, 3'b100, 20, 0, 0), nop);
        idle(3);

        // async reset while a stalled pair is held
        idle(4); clr_obs();
        step(1, 0, mk(1, 0, UNIT_SP_INT, 3'b000, 0, 1, 30), nop);
        step(1, 0, mk(1, 0, UNIT_FX1, 3'b100, 30, 0, 0), nop);
        idle(2);
        chk("pre_reset_stall", stall, 1'b1);
        in_valid = 1'b0; flush = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_even", issue_even_valid, 1'b0);
        chk("mid_rst_odd", issue_odd_valid, 1'b0);
        chk("mid_rst_dep", dep_stall_instr2, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        model_reset();
        #1;
        reset = 1'b1;
        clr_obs();
        step(1, 0, mk(1, 0, UNIT_FX1, 3'b100, 30, 0, 0), nop);
        idle(2);
        chk_int("post_rst_stalls", o_stall, 0);
        chk_int("post_rst_issue", o_even, 1);

        // randomized traffic on a small register window
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), mk_rand(), mk_rand());
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- In-order dual-issue scheduler between decode and the register-fetch stage of the SPU.
- Accepts one decoded instruction pair per handshake and tracks in-flight destination registers with per-register latency countdowns.
- Steers each instruction to the even or odd pipe, issuing both in the same cycle or instr1 alone, and stalls on RAW, structural and intra-pair hazards.
- Drives dep_stall_instr2 back to fetch/decode and honours branch flush.

Parameters:
- REG_ADDR_WIDTH, 7: register address width; 128 registers.
- UNIT_ID_SIZE, 3: execution-unit id width.
- LAT_W, 3: countdown width; must hold the maximum latency, 7.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode presents a pair
in_ready  out  1  scheduler can accept a pair
flush  in  1  branch taken; discard held instructions
iN_valid  in  1  (N=1,2) slot holds a real instruction
iN_pipe  in  1  0 = even, 1 = odd
iN_unit  in  UNIT_ID_SIZE  target unit id
iN_src_used  in  3  {ra,rb,rc} read mask
iN_ra, iN_rb, iN_rc  in  REG_ADDR_WIDTH  source addresses
iN_wr_en  in  1  writes rt
iN_rt  in  REG_ADDR_WIDTH  destination
issue_even_valid, issue_odd_valid  out  1  registered issue strobes
issue_even_slot, issue_odd_slot  out  1  0 = instr1, 1 = instr2
dep_stall_instr2  out  1  instr2 held while instr1 issued
stall  out  1  nothing issued this cycle although work is held

Behaviour:
- Reset (reset=0, async): state=IDLE, all countdowns 0, every output 0 except in_ready=1.
- Unit latency (cycles until the result reaches its forward point): fx1 2; byte, fx2, perm, branch 3; sp_fp, ls 6; sp_int 7.
- Scoreboard cnt[r], one per register:
  - When an instruction with wr_en issues, cnt[rt] <= LAT(unit).
  - Otherwise a nonzero count decrements by 1 each cycle.
  - Same-edge issue overrides the decrement.
  - Register 0 is not special.
- Readiness: an instruction is ready iff every used source s has cnt[s] <= 1, evaluated on registered cnt.
- States:
  - IDLE: in_ready=1. On in_valid, latch the pair → PAIR. If i1_valid=0, latch i2 as the sole instruction → SECOND.
  - PAIR, both valid: dual-issue at the next edge iff all of the following hold; then → IDLE.
    - both instructions ready;
    - i1_pipe != i2_pipe;
    - instr2 reads none of instr1's rt when i1_wr_en=1;
    - not both writing the same rt.
  - PAIR, else if instr1 ready: issue instr1 only, dep_stall_instr2=1 → SECOND.
  - PAIR, else: stall=1, stay.
  - SECOND: issue instr2 when ready → IDLE; else stall=1.
- Issue latency: strobes assert the cycle after the deciding edge and are high for exactly one cycle per instruction.
- Pipe selection: strobes are driven per pipe; the slot field says which instruction went there.
- Back-to-back: no bubble. in_ready is 1 in the cycle the held pair fully issues, so a new pair may be latched at the same edge.
- flush: synchronous.
  - Held instructions are dropped, no issue occurs that edge, state → IDLE.
  - cnt is not cleared (conservative).
  - flush with in_valid: the pair is not accepted.
- Reset mid-operation: immediate return to reset values. No partial issue strobe survives.

Optional Feature:
- Macro SCHED_STATS_EN.
- When defined, adds three 32-bit saturating output counters:
  - stat_dual: cycles with two issues.
  - stat_single: cycles with one issue.
  - stat_stall: cycles with stall=1.
- Counters reset to 0 and hold at 32'hFFFFFFFF.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package gets:
  - the unit-id enumeration;
  - the per-unit latency constants;
  - a packed typedef sched_instr_t {valid, pipe, unit, src_used, ra, rb, rc, wr_en, rt};
  - the state enum {IDLE, PAIR, SECOND}.
- Sub-module reg_scoreboard: countdown array with two set ports and six read ports, returning a ready flag per source.

Test Plan:
- Reset, then pair fx1 even (rt=5) + perm odd (rt=6), no deps → one cycle later both strobes high, slots 0/1; cnt[5]=2, cnt[6]=3.
- Pair where instr2 reads instr1's rt=5 → instr1 issues; dep_stall_instr2=1 for one cycle; instr2 issues on the following edge once cnt[5]<=1.
- Issue sp_int to rt=9, then a pair whose instr1 reads r9 → stall=1 for 6 cycles, then issue.
- Two even-pipe instructions → issued serially on consecutive cycles, never the same cycle.
- flush asserted in SECOND → no instr2 issue, in_ready=1 the next cycle, cnt values keep counting down.
- Reset asserted while in PAIR with a stall pending → strobes, stall and cnt are 0 immediately, with no clock edge needed.
